beta_bju_pipe: RTL

BETA_BJU_PIPE -- requirements
Module: beta_bju_pipe

---
 rtl/beta_pkg.sv | 28 ++
 rtl/beta_ras.sv | 64 ++++++
 rtl/beta_bju_pipe.sv | 118 +++++++++++
 3 files changed

// File: rtl/beta_pkg.sv
// rtl/beta_pkg.sv - shared BJU types: ALU status, BJU op, RAS hint, PC step
package beta_pkg;

  typedef logic [3:0] exe_alu_status_t;

  typedef enum logic [1:0] {
    BJU_EN_NONE   = 2'b00,
    BJU_EN_BRANCH = 2'b01,
    BJU_EN_JAL    = 2'b10,
    BJU_EN_JALR   = 2'b11
  } exe_bju_en_t;

  typedef struct packed {
    exe_bju_en_t exe_bju_en;
    logic [1:0]  exe_bju_condition_sel;
    logic        exe_bju_condition_neg;
  } exe_bju_op_t;

  typedef enum logic [1:0] {
    BJU_RAS_NONE    = 2'b00,
    BJU_RAS_PUSH    = 2'b01,
    BJU_RAS_POP     = 2'b10,
    BJU_RAS_POPPUSH = 2'b11
  } bju_ras_op_t;

  localparam int BJU_PC_STEP = 4;

endpackage

// File: rtl/beta_ras.sv
// rtl/beta_ras.sv - circular return-address stack with push/pop/poppush
module beta_ras
  import beta_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int RasDepth  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_valid,
  input  bju_ras_op_t          op,
  input  logic [DataWidth-1:0] push_data,
  output logic [DataWidth-1:0] pop_data,
  output logic                 empty
);

  localparam int PtrW = $clog2(RasDepth);

  logic [DataWidth-1:0] mem [RasDepth];
  logic [PtrW-1:0]      top_ptr;
  logic [PtrW-1:0]      top_idx;
  logic [PtrW-1:0]      wr_idx;
  logic [PtrW:0]        count;
  logic                 do_pop;
  logic                 do_push;

  // top_ptr names the next free slot; the live top sits one below it
  assign top_idx  = top_ptr - PtrW'(1);
  assign empty    = (count == '0);
  assign pop_data = empty ? '0 : mem[top_idx];

  assign do_pop  = op_valid & ~empty & ((op == BJU_RAS_POP) | (op == BJU_RAS_POPPUSH));
  assign do_push = op_valid & ((op == BJU_RAS_PUSH) | (op == BJU_RAS_POPPUSH));
  assign wr_idx  = do_pop ? top_idx : top_ptr;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_ptr <= '0;
      count   <= '0;
    end else begin
      case ({do_pop, do_push})
        2'b10: begin
          top_ptr <= top_idx;
          count   <= count - 1'b1;
        end
        2'b01: begin
          top_ptr <= top_ptr + PtrW'(1);
          if (count != (PtrW + 1)'(RasDepth)) begin
            count <= count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/beta_bju_pipe.sv
// rtl/beta_bju_pipe.sv - one-cycle branch/jump resolver; RAS built under BETA_BJU_RAS_EN
module beta_bju_pipe
  import beta_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int RasDepth  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [DataWidth-1:0] req_pc_i,
  input  logic [DataWidth-1:0] req_offset_i,
  input  logic [DataWidth-1:0] req_basereg_i,
  input  exe_alu_status_t      req_alu_stat_i,
  input  exe_bju_op_t          req_op_i,
  input  bju_ras_op_t          req_ras_op_i,
  input  logic                 flush_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [DataWidth-1:0] res_next_pc_o,
  output logic                 res_taken_o,
  output logic                 res_misalig_o,
  output logic                 res_ras_hit_o
);

  logic [DataWidth-1:0] pc_step;
  logic [DataWidth-1:0] pc_rel;
  logic [DataWidth-1:0] jalr_tgt;
  logic [DataWidth-1:0] target;
  logic                 cond;
  logic                 taken;
  logic                 misalig;
  logic                 accept;
  logic                 ras_hit;

  assign req_ready_o = ~res_valid_o | res_ready_i;
  assign accept      = req_valid_i & req_ready_o;

  assign pc_step  = req_pc_i + DataWidth'(BJU_PC_STEP);
  assign pc_rel   = req_pc_i + req_offset_i;
  assign jalr_tgt = (req_basereg_i + req_offset_i) & ~DataWidth'(1);
  assign cond     = req_alu_stat_i[req_op_i.exe_bju_condition_sel] == ~req_op_i.exe_bju_condition_neg;

  always_comb begin
    target = pc_step;
    taken  = 1'b0;
    case (req_op_i.exe_bju_en)
      BJU_EN_BRANCH: begin
        target = cond ? pc_rel : pc_step;
        taken  = cond;
      end
      BJU_EN_JAL: begin
        target = pc_rel;
        taken  = 1'b1;
      end
      BJU_EN_JALR: begin
        target = jalr_tgt;
        taken  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign misalig = |target[1:0];

`ifdef BETA_BJU_RAS_EN
  logic                 ras_update;
  logic [DataWidth-1:0] ras_top;
  logic                 ras_empty;

  // a flushed or misaligned request must leave the stack untouched
  assign ras_update = accept & ~misalig & ~flush_i;

  beta_ras #(
    .DataWidth(DataWidth),
    .RasDepth (RasDepth)
  ) u_ras (
    .clk      (clk_i),
    .rst      (rst_i),
    .op_valid (ras_update),
    .op       (req_ras_op_i),
    .push_data(pc_step),
    .pop_data (ras_top),
    .empty    (ras_empty)
  );

  assign ras_hit = ~misalig & ~ras_empty & (req_op_i.exe_bju_en == BJU_EN_JALR)
                 & ((req_ras_op_i == BJU_RAS_POP) | (req_ras_op_i == BJU_RAS_POPPUSH))
                 & (ras_top == target);
`else
  logic unused_ras_op;
  assign unused_ras_op = ^req_ras_op_i;
  assign ras_hit       = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_o   <= 1'b0;
      res_next_pc_o <= '0;
      res_taken_o   <= 1'b0;
      res_misalig_o <= 1'b0;
      res_ras_hit_o <= 1'b0;
    end else if (flush_i) begin
      res_valid_o <= 1'b0;
    end else if (accept) begin
      res_valid_o   <= 1'b1;
      res_next_pc_o <= misalig ? req_pc_i : target;
      res_taken_o   <= taken & ~misalig;
      res_misalig_o <= misalig;
      res_ras_hit_o <= ras_hit;
    end else if (res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

endmodule
